// File: rtl/key_logic_bank.sv
// Debounced multi-key logic gate: synchronises and debounces w_key push buttons,
// evaluates a switch-selected reduction function, and counts/toggles on result rising edges.
module key_logic_bank #(
    parameter int w_key           = 4,
    parameter int debounce_cycles = 500000,
    parameter int w_cnt           = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [w_key-1:0] key,
    input  logic [3:0]       sw,
    output logic [w_key-1:0] key_db,
    output logic             result,
    output logic             toggle,
    output logic [w_cnt-1:0] edge_count
);

    localparam int w_db = (debounce_cycles > 1) ? $clog2(debounce_cycles + 1) : 1;
    localparam logic [w_db-1:0] db_last = w_db'(debounce_cycles - 1);

    // Tie goes to 0 on majority because popcount must strictly exceed half.
    function automatic logic gate_eval(input logic [w_key-1:0] k, input logic [2:0] op);
        int  pop;
        logic g;
        pop = 0;
        for (int i = 0; i < w_key; i++) begin
            pop = pop + int'(k[i]);
        end
        case (op)
            3'd0:    g = &k;
            3'd1:    g = |k;
            3'd2:    g = ^k;
            3'd3:    g = ~(&k);
            3'd4:    g = ~(|k);
            3'd5:    g = ~(^k);
            3'd6:    g = (pop > (w_key / 2));
            3'd7:    g = (&k) | ~(|k);
            default: g = 1'b0;
        endcase
        return g;
    endfunction

    logic [w_key-1:0] key_meta_r;
    logic [w_key-1:0] key_sync_r;
    logic [3:0]       sw_meta_r;
    logic [3:0]       sw_sync_r;
    logic [w_db-1:0]  db_cnt_r [w_key];
    logic [w_key-1:0] key_db_r;
    logic             result_r;
    logic             result_d_r;
    logic             toggle_r;
    logic [w_cnt-1:0] edge_count_r;
    logic             gate_s;
    logic             rise_s;

    // Two-flop synchronisers for the raw keys and switches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_r <= {w_key{1'b0}};
            key_sync_r <= {w_key{1'b0}};
            sw_meta_r  <= 4'b0000;
            sw_sync_r  <= 4'b0000;
        end else begin
            key_meta_r <= key;
            key_sync_r <= key_meta_r;
            sw_meta_r  <= sw;
            sw_sync_r  <= sw_meta_r;
        end
    end

    // Per-key debounce: accept a new level only after it is stable for debounce_cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_db_r <= {w_key{1'b0}};
            for (int i = 0; i < w_key; i++) begin
                db_cnt_r[i] <= {w_db{1'b0}};
            end
        end else begin
            for (int i = 0; i < w_key; i++) begin
                if (key_sync_r[i] == key_db_r[i]) begin
                    db_cnt_r[i] <= {w_db{1'b0}};
                end else if (db_cnt_r[i] == db_last) begin
                    key_db_r[i] <= key_sync_r[i];
                    db_cnt_r[i] <= {w_db{1'b0}};
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + w_db'(1);
                end
            end
        end
    end

    // Gate evaluation and rising-edge detect on the registered result.
    always_comb begin
        gate_s = 1'b0;
        rise_s = 1'b0;
        gate_s = gate_eval(key_db_r, sw_sync_r[2:0]);
        rise_s = result_r & ~result_d_r;
    end

    // Result pipeline, edge counter and toggle flip-flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r     <= 1'b0;
            result_d_r   <= 1'b0;
            toggle_r     <= 1'b0;
            edge_count_r <= {w_cnt{1'b0}};
        end else begin
            result_r   <= gate_s;
            result_d_r <= result_r;
            if (rise_s) begin
                edge_count_r <= edge_count_r + w_cnt'(1);
                if (sw_sync_r[3]) begin
                    toggle_r <= ~toggle_r;
                end else begin
                    toggle_r <= toggle_r;
                end
            end else begin
                edge_count_r <= edge_count_r;
                toggle_r     <= toggle_r;
            end
        end
    end

    assign key_db     = key_db_r;
    assign result     = result_r;
    assign toggle     = toggle_r;
    assign edge_count = edge_count_r;

endmodule

// File: tb/tb_key_logic_bank.sv
// Directed self-checking bench for key_logic_bank with debounce_cycles=4; a second
// instance with a 2-bit counter exercises counter wrap.
module tb_key_logic_bank;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [3:0] sw;
    logic [3:0] key_db;
    logic       result;
    logic       toggle;
    logic [5:0] edge_count;
    logic [3:0] key_db2;
    logic       result2;
    logic       toggle2;
    logic [1:0] edge_count2;

    int errors;
    int checks;

    key_logic_bank #(.w_key(4), .debounce_cycles(4), .w_cnt(6)) dut (
        .clk(clk), .rst(rst), .key(key), .sw(sw),
        .key_db(key_db), .result(result), .toggle(toggle), .edge_count(edge_count)
    );

    key_logic_bank #(.w_key(4), .debounce_cycles(4), .w_cnt(2)) dut_wrap (
        .clk(clk), .rst(rst), .key(key), .sw(sw),
        .key_db(key_db2), .result(result2), .toggle(toggle2), .edge_count(edge_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
    endtask

    task automatic press(input int idx);
        key[idx] = 1'b1;
        cycles(9);
        key[idx] = 1'b0;
        cycles(9);
    endtask

    task automatic test_reset();
        key = 4'b0000;
        sw  = 4'b0000;
        do_reset();
        checks++;
        if ({key_db, result, toggle, edge_count} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h want 000", {key_db, result, toggle, edge_count});
        end
    endtask

    task automatic test_bounce();
        logic [10:0] pat;
        pat = 11'b01110111000;
        for (int i = 0; i < 11; i++) begin
            key[0] = pat[10 - i];
            cycles(1);
            checks++;
            if (key_db[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_kdb cycle %0d got %b want 0", i, key_db[0]);
            end
        end
        cycles(6);
        checks++;
        if (key_db !== 4'b0000 || edge_count !== 6'd0) begin
            errors++;
            $display("FAIL bounce_final got kdb=%b cnt=%0d want kdb=0000 cnt=0", key_db, edge_count);
        end
    endtask

    task automatic test_latency();
        sw  = 4'b0000;
        key = 4'b1111;
        cycles(6);
        checks++;
        if (key_db !== 4'b1111 || result !== 1'b0) begin
            errors++;
            $display("FAIL latency_c6 got kdb=%b res=%b want kdb=1111 res=0", key_db, result);
        end
        cycles(1);
        checks++;
        if (result !== 1'b1 || edge_count !== 6'd0) begin
            errors++;
            $display("FAIL latency_c7 got res=%b cnt=%0d want res=1 cnt=0", result, edge_count);
        end
        cycles(1);
        checks++;
        if (edge_count !== 6'd1) begin
            errors++;
            $display("FAIL latency_count got %0d want 1", edge_count);
        end
    endtask

    task automatic test_op_sweep();
        logic [7:0] exp_tab;
        logic       prev;
        exp_tab = 8'b01001110;
        key = 4'b0111;
        cycles(10);
        prev = 1'b0;
        for (int op = 0; op < 8; op++) begin
            sw = {1'b0, 3'(op)};
            cycles(2);
            checks++;
            if (result !== prev) begin
                errors++;
                $display("FAIL op_hold op=%0d got %b want %b", op, result, prev);
            end
            cycles(1);
            checks++;
            if (result !== exp_tab[op]) begin
                errors++;
                $display("FAIL op_result op=%0d got %b want %b", op, result, exp_tab[op]);
            end
            prev = exp_tab[op];
        end
        cycles(2);
        checks++;
        if (edge_count !== 6'd3) begin
            errors++;
            $display("FAIL op_count got %0d want 3", edge_count);
        end
    endtask

    task automatic test_toggle();
        logic [2:0] exp_tog;
        exp_tog = 3'b101;
        key = 4'b0000;
        sw  = 4'b1010;
        do_reset();
        cycles(4);
        checks++;
        if (toggle !== 1'b0 || result !== 1'b0) begin
            errors++;
            $display("FAIL toggle_start got tog=%b res=%b want 0 0", toggle, result);
        end
        for (int p = 0; p < 3; p++) begin
            press(1);
            checks++;
            if (toggle !== exp_tog[p] || edge_count !== 6'(p + 1)) begin
                errors++;
                $display("FAIL toggle_press %0d got tog=%b cnt=%0d want tog=%b cnt=%0d",
                         p, toggle, edge_count, exp_tog[p], p + 1);
            end
        end
        sw = 4'b0010;
        cycles(4);
        for (int p = 0; p < 2; p++) begin
            press(1);
            checks++;
            if (toggle !== 1'b1 || edge_count !== 6'(p + 4)) begin
                errors++;
                $display("FAIL level_press %0d got tog=%b cnt=%0d want tog=1 cnt=%0d",
                         p, toggle, edge_count, p + 4);
            end
        end
    endtask

    task automatic test_reset_mid();
        key = 4'b1111;
        cycles(1);
        checks++;
        if (edge_count !== 6'd5) begin
            errors++;
            $display("FAIL midreset_pre got cnt=%0d want 5", edge_count);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({key_db, result, toggle, edge_count} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_async got %h want 000", {key_db, result, toggle, edge_count});
        end
        cycles(2);
        rst = 1'b0;
        cycles(5);
        checks++;
        if (key_db !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_c5 got %b want 0000", key_db);
        end
        cycles(1);
        checks++;
        if (key_db !== 4'b1111) begin
            errors++;
            $display("FAIL midreset_c6 got %b want 1111", key_db);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_seq;
        exp_seq = {2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
        key = 4'b0000;
        sw  = 4'b0001;
        do_reset();
        cycles(4);
        for (int p = 0; p < 5; p++) begin
            press(0);
            checks++;
            if (edge_count2 !== exp_seq[2*p +: 2]) begin
                errors++;
                $display("FAIL wrap_count %0d got %0d want %0d", p, edge_count2, exp_seq[2*p +: 2]);
            end
        end
        checks++;
        if (edge_count !== 6'd5) begin
            errors++;
            $display("FAIL wrap_wide got %0d want 5", edge_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        key = 4'b0000;
        sw  = 4'b0000;
        #1;
        test_reset();
        test_bounce();
        test_latency();
        test_op_sweep();
        test_toggle();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
